// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle.
// Groups the ROM port, the IR handshake towards the decoder and the branch
// resolution inputs from the execute side.
//   master : fetch unit side (drives instr_address, ir, ir_valid, pc)
//   slave  : environment side (ROM, decoder and execute drive the rest)
interface fetch_unit_if #(
  parameter int BUS_WIDTH = 16
);
  logic [BUS_WIDTH-1:0] instr_address;
  logic [BUS_WIDTH-1:0] instruction;
  logic [BUS_WIDTH-1:0] ir;
  logic                 ir_valid;
  logic                 ir_ready;
  logic                 br_valid;
  logic                 br_zero;
  logic [BUS_WIDTH-1:0] br_target;
  logic [BUS_WIDTH-1:0] pc;

  modport master (
    output instr_address, ir, ir_valid, pc,
    input  instruction, ir_ready, br_valid, br_zero, br_target
  );

  modport slave (
    input  instr_address, ir, ir_valid, pc,
    output instruction, ir_ready, br_valid, br_zero, br_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch stage sitting in front of the instruction ROM.
// Reads the ROM at pc, captures the word into ir and offers it to the
// decoder over a valid/ready handshake. BRZ/JMP words stall fetch until the
// execute side returns the branch outcome.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_if.master: instr_address/instruction (ROM),
//          ir/ir_valid/ir_ready (decoder), br_valid/br_zero/br_target
//          (execute), pc (debug/trace)
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | ROM addressed by pc; ir captures the returned word at the edge
// ISSUE   | ir_valid high, ir held until the decoder accepts it
// WAIT_BR | BRZ/JMP accepted; pc frozen until br_valid resolves it
module fetch_unit #(
  parameter int                   BUS_WIDTH = 16,
  parameter logic [BUS_WIDTH-1:0] PC_RESET  = '0,
  parameter int                   OFF_WIDTH = 6
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    ISSUE   = 2'd1,
    WAIT_BR = 2'd2
  } state_t;

  localparam logic [BUS_WIDTH-1:0] ONE = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_WIDTH-1:0] ir_q, ir_d;
  logic                 ir_valid_q, ir_valid_d;

  // BRZ offset is split across the rd and rsB fields of the word.
  logic [OFF_WIDTH-1:0] br_off;
  logic [BUS_WIDTH-1:0] br_off_sext;
  logic [BUS_WIDTH-1:0] pc_inc;

  assign br_off      = {ir_q[8:6], ir_q[2:0]};
  assign br_off_sext = {{(BUS_WIDTH-OFF_WIDTH){br_off[OFF_WIDTH-1]}}, br_off};
  assign pc_inc      = pc_q + ONE;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      FETCH: begin
        ir_d       = bus.instruction;
        ir_valid_d = 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: begin
        if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
          // ir[15:14] == 2'b11 covers both BRZ (110) and JMP (111).
          if (ir_q[15:14] == 2'b11) begin
            state_d = WAIT_BR;
          end else begin
            pc_d    = pc_inc;
            state_d = FETCH;
          end
        end
      end
      WAIT_BR: begin
        if (bus.br_valid) begin
          if (ir_q[15:13] == 3'b111) begin
            pc_d = bus.br_target;
          end else if (bus.br_zero) begin
            pc_d = pc_q + br_off_sext;
          end else begin
            pc_d = pc_inc;
          end
          state_d = FETCH;
        end
      end
      default: begin
        ir_valid_d = 1'b0;
        state_d    = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= PC_RESET;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // ROM address comes straight from the pc register only.
  assign bus.instr_address = pc_q;
  assign bus.ir            = ir_q;
  assign bus.ir_valid      = ir_valid_q;
  assign bus.pc            = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] word;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [15:0] rom [65536];
  exp_t exp_q[$];
  logic [15:0] mpc;
  int vectors;
  int miscompares;
  bit mon_en;
  bit expect_idle;

  fetch_unit_if #(.BUS_WIDTH(16)) bus ();

  fetch_unit #(
    .BUS_WIDTH(16),
    .PC_RESET (16'h0000),
    .OFF_WIDTH(6)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  assign bus.instruction = rom[bus.instr_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compares whatever the DUT offers against the head of
  // the expected queue and retires the entry on a handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (expect_idle) begin
          chk("sb_valid_drop", 16'(bus.ir_valid), 16'd0);
          expect_idle = 1'b0;
        end
        if (bus.ir_valid) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_issue", 16'(exp_q.size()), 16'd1);
          end else begin
            chk("sb_ir", bus.ir, exp_q[0].word);
            chk("sb_pc", bus.pc, exp_q[0].pc);
            chk("sb_addr", bus.instr_address, exp_q[0].pc);
            if (bus.ir_ready) begin
              void'(exp_q.pop_front());
              expect_idle = 1'b1;
            end
          end
        end
      end
    end
  end

  function automatic logic [15:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'd22;
      2:       return 16'd20;
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference model: next pc from the accepted word and the branch outcome.
  task automatic run_random(input int n);
    logic [15:0] nxt;
    logic [15:0] w;
    int off;
    int g;
    int hs;
    int nw;
    for (int i = 0; i < n; i++) begin
      g = 0;
      do begin
        @(posedge clk); #1;
        br_noise();
        g++;
      end while (!bus.ir_valid && g < 8);
      if (!bus.ir_valid) begin
        chk("issue_timeout", 16'(bus.ir_valid), 16'd1);
        return;
      end
      hs = 0;
      forever begin
        bus.ir_ready = (hs >= 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
        if (bus.ir_ready) break;
        @(posedge clk); #1;
        br_noise();
        hs++;
      end
      w = rom[mpc];
      if (w[15:14] == 2'b11) begin
        @(posedge clk); #1;
        bus.br_valid = 1'b0;
        bus.ir_ready = 1'($urandom);
        nw = $urandom_range(0, 4);
        repeat (nw) begin
          @(posedge clk); #1;
          bus.ir_ready = 1'($urandom);
        end
        bus.br_valid  = 1'b1;
        bus.br_zero   = 1'($urandom);
        bus.br_target = pick_target();
        if (w[13]) begin
          nxt = bus.br_target;
        end else if (bus.br_zero) begin
          off = int'({w[8:6], w[2:0]});
          if (off >= 32) off -= 64;
          nxt = 16'((int'(mpc) + off + 65536) % 65536);
        end else begin
          nxt = mpc + 16'd1;
        end
        @(posedge clk); #1;
        bus.br_valid = 1'b0;
      end else begin
        nxt = mpc + 16'd1;
      end
      mpc = nxt;
      exp_q.push_back('{pc: nxt, word: rom[nxt]});
    end
  endtask

  task automatic br_noise();
    bus.br_valid  = ($urandom_range(0, 3) == 0);
    bus.br_zero   = 1'($urandom);
    bus.br_target = 16'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    vectors      = 0;
    miscompares  = 0;
    mon_en       = 1'b0;
    expect_idle  = 1'b0;
    for (int a = 0; a < 65536; a++) rom[a] = 16'($urandom);
    rom[0]      = 16'b100_1100_000_000_000;
    rom[1]      = 16'h9841;
    rom[2]      = 16'h9882;
    rom[3]      = 16'h98C3;
    rom[4]      = 16'hE012;
    rom[20]     = 16'h9800;
    rom[21]     = 16'h9801;
    rom[22]     = 16'b110_0000_000_010_010;
    rom[23]     = 16'b111_0000_000_010_010;
    rom[24]     = 16'h9802;
    rom[26]     = 16'b110_0000_111_010_110;
    rom[28]     = 16'hC000;
    rom[16'hFFFF] = 16'h9803;

    rst_n         = 1'b0;
    bus.ir_ready  = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_zero   = 1'b0;
    bus.br_target = 16'h0000;
    #3;
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_ir", bus.ir, 16'h0000);
    chk("rst_valid", 16'(bus.ir_valid), 16'd0);
    chk("rst_addr", bus.instr_address, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("first_fetch_valid", 16'(bus.ir_valid), 16'd0);
    chk("first_fetch_addr", bus.instr_address, 16'h0000);
    bus.ir_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("seq_valid", 16'(bus.ir_valid), 16'd1);
      chk("seq_ir", bus.ir, rom[k]);
      chk("seq_pc", bus.pc, 16'(k));
      if (k == 2) begin
        bus.ir_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk("bp_valid", 16'(bus.ir_valid), 16'd1);
          chk("bp_ir", bus.ir, rom[2]);
          chk("bp_pc", bus.pc, 16'd2);
          chk("bp_addr", bus.instr_address, 16'd2);
        end
        bus.ir_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk("seq_gap_valid", 16'(bus.ir_valid), 16'd0);
      chk("seq_next_pc", bus.pc, 16'(k + 1));
    end

    // JMP at 4: a br_valid pulse while in ISSUE must be ignored.
    @(posedge clk); #1;
    bus.ir_ready  = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 16'h1234;
    @(posedge clk); #1;
    bus.br_valid = 1'b0;
    chk("issue_brv_valid", 16'(bus.ir_valid), 16'd1);
    chk("issue_brv_pc", bus.pc, 16'd4);
    bus.ir_ready = 1'b1;
    @(posedge clk); #1;
    repeat (3) begin
      chk("waitbr_valid", 16'(bus.ir_valid), 16'd0);
      chk("waitbr_pc", bus.pc, 16'd4);
      @(posedge clk); #1;
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wait_pc", bus.pc, 16'h0000);
    chk("arst_wait_ir", bus.ir, 16'h0000);
    chk("arst_wait_valid", 16'(bus.ir_valid), 16'd0);
    chk("arst_wait_addr", bus.instr_address, 16'h0000);

    // Randomized run against the reference model.
    repeat (2) @(posedge clk);
    mpc = 16'h0000;
    exp_q.delete();
    exp_q.push_back('{pc: 16'h0000, word: rom[0]});
    expect_idle = 1'b0;
    mon_en      = 1'b1;
    #1 rst_n = 1'b1;
    run_random(300);

    bus.ir_ready = 1'b0;
    bus.br_valid = 1'b0;
    g = 0;
    while (!bus.ir_valid && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    chk("pre_arst_issue", 16'(bus.ir_valid), 16'd1);
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_issue_pc", bus.pc, 16'h0000);
    chk("arst_issue_ir", bus.ir, 16'h0000);
    chk("arst_issue_valid", 16'(bus.ir_valid), 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_valid", 16'(bus.ir_valid), 16'd1);
    chk("restart_pc", bus.pc, 16'h0000);
    chk("restart_ir", bus.ir, rom[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
